// File: rtl/rv32.sv
// Shared rv32 core types.
package rv32;
  typedef logic [31:0] word;
endpackage

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller: load-use bubbles, data-memory wait/timeout,
// branch/trap redirects and the post-redirect fetch-flush window.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT  = 16,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       ex_valid,
  input  logic       ex_is_load,
  input  logic [4:0] ex_rd,
  input  logic       ex_branch_taken,
  input  rv32::word  ex_branch_target,
  input  logic       mem_req,
  input  logic       mem_ack,
  input  logic       trap_i,
  input  rv32::word  trap_vector,
  output logic       stall_fetch,
  output logic       stall_decode,
  output logic       stall_ex,
  output logic       flush_if,
  output logic       bubble_ex,
  output logic       flush_ex,
  output logic       pc_redirect,
  output rv32::word  pc_target,
  output logic       mem_timeout,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StFlush   = 2'd2
  } state_e;

  localparam logic [7:0] WaitLast  = 8'(MEM_TIMEOUT - 1);
  localparam logic [2:0] FlushLast = 3'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [2:0] flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic mem_stall;

  assign load_use = ex_valid && ex_is_load && id_valid && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
  assign mem_stall = mem_req && !mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      wait_cnt_q  <= 8'd0;
      flush_cnt_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    stall_fetch  = 1'b0;
    stall_decode = 1'b0;
    stall_ex     = 1'b0;
    flush_if     = 1'b0;
    bubble_ex    = 1'b0;
    flush_ex     = 1'b0;
    pc_redirect  = 1'b0;
    pc_target    = '0;
    mem_timeout  = 1'b0;
    state_o      = state_q;

    if (!rst_n) begin
      // Pipeline registers see bubbles while the core is held in reset.
      flush_if  = 1'b1;
      bubble_ex = 1'b1;
      state_o   = 2'd0;
    end else if (trap_i) begin
      pc_redirect = 1'b1;
      pc_target   = trap_vector;
      flush_if    = 1'b1;
      flush_ex    = 1'b1;
      state_d     = StFlush;
      flush_cnt_d = 3'd0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (mem_stall) begin
            stall_fetch  = 1'b1;
            stall_decode = 1'b1;
            stall_ex     = 1'b1;
            state_d      = StMemWait;
            wait_cnt_d   = 8'd0;
          end else if (ex_branch_taken) begin
            pc_redirect = 1'b1;
            pc_target   = ex_branch_target;
            flush_if    = 1'b1;
            bubble_ex   = 1'b1;
            state_d     = StFlush;
            flush_cnt_d = 3'd0;
          end else if (load_use) begin
            stall_fetch  = 1'b1;
            stall_decode = 1'b1;
            bubble_ex    = 1'b1;
          end
        end
        StMemWait: begin
          if (mem_ack) begin
            state_d = StRun;
          end else begin
            stall_fetch  = 1'b1;
            stall_decode = 1'b1;
            stall_ex     = 1'b1;
            if (wait_cnt_q == WaitLast) begin
              mem_timeout = 1'b1;
              state_d     = StRun;
            end else begin
              wait_cnt_d = wait_cnt_q + 8'd1;
            end
          end
        end
        StFlush: begin
          flush_if = 1'b1;
          if (mem_stall) begin
            // Window is frozen while memory holds the pipe.
            stall_fetch  = 1'b1;
            stall_decode = 1'b1;
            stall_ex     = 1'b1;
          end else if (flush_cnt_q == FlushLast) begin
            state_d = StRun;
          end else begin
            flush_cnt_d = flush_cnt_q + 3'd1;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the rv32 in-order core. It generates the stall, bubble, flush and PC-redirect controls consumed by the fetch stage, the IF/ID register and the downstream ID/EX and EX/MEM registers. It resolves four conditions: load-use data hazards, data-memory wait states (with a timeout), taken branches, and traps. Branches and traps are followed by a configurable fetch-flush window.

## Interface
Parameters:
- MEM_TIMEOUT, default 16: maximum MEM_WAIT cycles without ack before a timeout. Legal range 2..255.
- FLUSH_CYCLES, default 1: number of cycles after a redirect during which fetched instructions are killed. Legal range 1..7.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; one clock, asynchronous assert, active-low
- id_valid  in  1  decode stage holds a real instruction
- id_rs1, id_rs2  in  5 each  decode source registers
- id_uses_rs1, id_uses_rs2  in  1 each  decode actually reads rs1 / rs2
- ex_valid  in  1  execute stage holds a real instruction
- ex_is_load  in  1  execute instruction is a load
- ex_rd  in  5  execute destination register
- ex_branch_taken  in  1  execute resolved a taken branch or jump
- ex_branch_target  in  rv32::word  branch target
- mem_req  in  1  memory stage has a data access outstanding this cycle
- mem_ack  in  1  data memory completes the access this cycle
- trap_i  in  1  trap request
- trap_vector  in  rv32::word  trap handler address
- stall_fetch  out  1  hold PC and fetch
- stall_decode  out  1  hold the IF/ID register
- stall_ex  out  1  hold ID/EX and EX/MEM
- flush_if  out  1  drives the IF/ID bubble input
- bubble_ex  out  1  load a bubble into ID/EX
- flush_ex  out  1  kill ID/EX and EX/MEM contents
- pc_redirect  out  1  load pc_target into the PC
- pc_target  out  rv32::word  redirect address
- mem_timeout  out  1  single-cycle pulse when a data access times out
- state_o  out  2  FSM state: RUN=0, MEM_WAIT=1, FLUSH=2

## Operation
- The FSM is registered. All outputs are Mealy combinational functions of the state, the counters and the inputs.
- Load-use hazard (lu) is true when all of the following hold:
  - ex_valid, ex_is_load and id_valid are set, and ex_rd is not 0;
  - id_uses_rs1 with id_rs1 equal to ex_rd, or id_uses_rs2 with id_rs2 equal to ex_rd.
- Priority within a cycle: trap_i, then memory wait, then branch, then lu.
- trap_i, in any state:
  - pc_redirect=1 with pc_target=trap_vector; flush_if=1, flush_ex=1; all stalls 0.
  - Next state is FLUSH with flush_cnt=0. An in-progress MEM_WAIT is abandoned.
- RUN:
  - mem_req with no mem_ack: stall_fetch, stall_decode and stall_ex are 1. Next state is MEM_WAIT with wait_cnt=0.
  - Otherwise ex_branch_taken: pc_redirect=1 with pc_target=ex_branch_target; flush_if=1, bubble_ex=1. Next state is FLUSH with flush_cnt=0. lu is ignored that cycle.
  - Otherwise lu: stall_fetch=1, stall_decode=1, bubble_ex=1 for that cycle only. The state stays RUN.
- MEM_WAIT:
  - stall_fetch, stall_decode and stall_ex are 1 unless mem_ack is high. Branch and lu are ignored.
  - mem_ack: stalls drop in the same cycle and the next state is RUN.
  - No ack with wait_cnt equal to MEM_TIMEOUT-1: mem_timeout=1 with stalls still 1, and the next state is RUN.
  - Otherwise wait_cnt increments.
- FLUSH:
  - flush_if=1 every cycle. lu and ex_branch_taken are ignored, because execute holds a killed bubble.
  - mem_req with no mem_ack: all three stalls are 1 and flush_cnt holds.
  - Otherwise, when flush_cnt equals FLUSH_CYCLES-1 the next state is RUN; else flush_cnt increments.
- pc_target is 0 whenever pc_redirect is 0.
- Upstream holds ex_branch_taken and ex_branch_target stable while stall_ex is high.
- Counter widths: wait_cnt is 8 bits and flush_cnt is 3 bits. Neither counter wraps; both are cleared on entry to their state.

## Timing
- During reset and after release: state is RUN and both counters are 0. In the first cycle after release, flush_if=0.
- While rst_n is low, outputs are forced: flush_if=1, bubble_ex=1; everything else 0, including pc_target and state_o.
- Reset mid-MEM_WAIT or mid-FLUSH returns to RUN immediately, regardless of the clock.
- Redirect latency is zero: pc_redirect is asserted in the same cycle as ex_branch_taken or trap_i.
- flush_if is high in the redirect cycle and in the next FLUSH_CYCLES cycles, plus any cycles frozen by a memory stall.
- Load-use costs exactly one bubble cycle.
- Memory stall length equals the cycles until mem_ack, or MEM_TIMEOUT MEM_WAIT cycles plus the entry cycle.

## Test plan
- Reset: hold rst_n low for 3 cycles, then release. Required: flush_if=1 and bubble_ex=1 while low; state_o=0 with all stalls 0 after release.
- Load-use: ex loads x5; decode has rs2=x5 with id_uses_rs2=1. Required: stall_fetch=stall_decode=bubble_ex=1 for one cycle only. With ex_rd=0, nothing is asserted.
- Branch: ex_branch_taken with target 0x0000_0100 and FLUSH_CYCLES=2. Required: pc_redirect=1 and pc_target=0x100 in cycle 0; flush_if=1 in cycles 0-2; state_o=2 in cycles 1-2; RUN in cycle 3.
- Memory wait: mem_req with ack delayed 3 cycles. Required: stalls high for 3 cycles and drop in the ack cycle; state_o=1 during the wait.
- Timeout: MEM_TIMEOUT=4 with ack never asserted. Required: mem_timeout pulses once, in the 4th MEM_WAIT cycle; then RUN with stalls low.
- Trap during MEM_WAIT with a simultaneous branch: trap_vector=0x0000_0004. Required: pc_target=0x4, flush_ex=1, state_o=2 next cycle, no mem_timeout; the branch is ignored.
